// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared fetch FSM states, redirect event priorities and address constants.
package pc_sequencer_pkg;
  typedef enum logic [1:0] {BOOT, REQ, STALL, TRAP} state_e;
  typedef enum logic [2:0] {EVT_NONE, EVT_BR, EVT_JMP, EVT_ERET, EVT_EXC} evt_e;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;
endpackage

// File: rtl/pc_sequencer_event_prio.sv
// pc_event_prio: picks the highest-priority incoming redirect and its word-aligned target.
module pc_event_prio
  import pc_sequencer_pkg::*;
(
  input  logic        exc_i,
  input  logic        eret_i,
  input  logic        jmp_i,
  input  logic        br_i,
  input  logic [31:0] br_target_i,
  input  logic [31:0] jmp_target_i,
  input  logic [31:0] epc_i,
  output evt_e        evt_o,
  output logic [31:0] target_o
);
  always_comb begin
    evt_o = exc_i ? EVT_EXC : eret_i ? EVT_ERET : jmp_i ? EVT_JMP : br_i ? EVT_BR : EVT_NONE;
    target_o = exc_i ? EXC_VECTOR : eret_i ? epc_i :
               jmp_i ? {jmp_target_i[31:2], 2'b00} : {br_target_i[31:2], 2'b00};
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, drives the imem request handshake and buffers redirects until a handshake.
module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        jmp_i,
  input  logic [31:0] jmp_target_i,
  input  logic        exc_i,
  input  logic        eret_i,
  input  logic        imem_ready_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] pc_o,
  output logic        fetch_valid_o,
  output logic [31:0] epc_o
);
  state_e state, state_nxt;
  evt_e in_evt, pend_evt, evt;
  logic [31:0] pc, epc, in_tgt, pend_tgt, tgt;
  logic hs, active;

  pc_event_prio u_prio (
    .exc_i(exc_i), .eret_i(eret_i), .jmp_i(jmp_i), .br_i(br_taken_i),
    .br_target_i(br_target_i), .jmp_target_i(jmp_target_i), .epc_i(epc),
    .evt_o(in_evt), .target_o(in_tgt)
  );

  // An incoming event replaces the pending one on equal or higher priority.
  always_comb begin
    evt = (in_evt >= pend_evt) ? in_evt : pend_evt;
    tgt = (in_evt >= pend_evt) ? in_tgt : pend_tgt;
    hs = (state == REQ) && imem_ready_i;
    active = (state == REQ) || (state == STALL);
    state_nxt = (state == BOOT || state == TRAP) ? REQ :
                (state == REQ && !imem_ready_i) ? REQ :
                (((state == REQ) ? evt : in_evt) == EVT_EXC) ? TRAP :
                stall_i ? STALL : REQ;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= BOOT;
    else state <= state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      epc <= '0;
      pend_evt <= EVT_NONE;
      pend_tgt <= '0;
    end else begin
      if (active && in_evt == EVT_EXC) epc <= pc;
      if (hs) begin
        pc <= (evt == EVT_NONE) ? pc + INSTR_BYTES : tgt;
        pend_evt <= EVT_NONE;
      end else if (state == REQ) begin
        pend_evt <= evt;
        pend_tgt <= tgt;
      end else if (state == STALL && in_evt != EVT_NONE) begin
        pc <= in_tgt;
      end
    end
  end

  assign imem_req_o = (state == REQ);
  assign imem_addr_o = pc;
  assign pc_o = pc;
  assign epc_o = epc;
  assign fetch_valid_o = hs && (evt == EVT_NONE);
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller that owns the program counter and sequences instruction fetch for the single-cycle CPU core. It issues a request/ready handshake to instruction memory, computes the next PC (sequential, branch, jump, exception entry, exception return) and absorbs stalls. Redirects that arrive while a fetch is outstanding are buffered and applied at the next handshake boundary.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- EXC_VECTOR, 32'h0000_0080, exception entry address
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall_i  in  1  hazard stall; holds fetch after current handshake
- br_taken_i  in  1  branch-taken pulse; br_target_i  in  32  branch target
- jmp_i  in  1  jump pulse; jmp_target_i  in  32  jump/jr target
- exc_i  in  1  exception pulse for instruction at pc_o
- eret_i  in  1  exception-return pulse
- imem_ready_i  in  1  instruction memory accepts and returns this cycle
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address (= pc_o)
- pc_o  out  32  current PC
- fetch_valid_o  out  1  fetched word at pc_o is architecturally valid
- epc_o  out  32  saved exception PC

## Operation
- States: BOOT, REQ, STALL, TRAP (encoding from shared package).
- BOOT: entered on reset; imem_req_o=0; exactly one cycle, then REQ. Events during BOOT ignored.
- REQ: imem_req_o=1, imem_addr_o=pc. Handshake = req & imem_ready_i. Without handshake, addr held stable; state held.
- On handshake: pc <= next PC; next state TRAP if the applied event is an exception, else STALL if stall_i, else REQ.
- STALL: req=0; events apply directly to pc each cycle; returns to REQ the cycle after stall_i falls.
- TRAP: req=0 for one cycle; pc already = EXC_VECTOR; then REQ.
- Event priority: exc > eret > jmp > br > sequential (pc+4, modulo 2^32, 32'hFFFF_FFFC wraps to 0).
- Pending slot: event arriving in REQ without handshake is latched with its target; a later event overwrites only if priority ≥ stored. Applied at next handshake; that handshake's fetch_valid_o=0 (squash). Event coincident with handshake is applied on that handshake, also squashed.
- exc: epc_o <= pc_o of the excepting instruction (pc at time of exc_i, not the target). eret: next PC = epc_o.
- Targets are word-aligned by caller; bits [1:0] forced to 0.

## Timing
- Reset values: pc_o=RESET_PC, imem_addr_o=RESET_PC, imem_req_o=0, fetch_valid_o=0, epc_o=0, pending empty, state BOOT.
- First request one cycle after rst deasserts.
- fetch_valid_o = handshake & no event applied this handshake (combinational on imem_ready_i).
- PC update latency: 1 cycle after handshake. Redirect-to-new-fetch: 1 cycle (REQ), 2 cycles via TRAP.
- Reset mid-fetch: request drops immediately (asynchronous), pending cleared.
- stall_i and event same cycle in REQ with handshake: event applied, state STALL (or TRAP for exc).

## Structure
- Shared package: state enum, EVT priority encoding, INSTR_BYTES=4 constant.
- Optional sub-module pc_event_prio: combinational priority select of event and target; rest in one always block plus next-PC mux.

## Test plan
- Reset, imem_ready_i=1 constant -> BOOT 1 cycle, then addresses 0x0,0x4,0x8 each cycle with fetch_valid_o=1.
- ready low 3 cycles at pc=0x8, br_taken_i pulse target 0x40 in cycle 1 -> addr stays 0x8, handshake squashed, next fetch 0x40.
- jmp 0x100 and br 0x40 same cycle -> next fetch 0x100.
- exc_i at pc=0x20 -> epc_o=0x20, one req-low cycle, fetch 0x80; later eret_i -> fetch 0x20.
- stall_i high 2 cycles after fetch 0xC -> req low 2 cycles, then fetch 0x10; pc 0xFFFF_FFFC sequential -> 0x0.
- rst asserted while req outstanding -> req=0 immediately, pc_o=RESET_PC, pending cleared.
